// File: rtl/tl_sched_if.sv
// tl_sched_if: sensor/request inputs and light outputs of the intersection scheduler.
// The master side (controller or bench) drives the sensors. The slave side (tl_sched) drives the lamps.
interface tl_sched_if;
    logic       Ta;       // road A vehicle present
    logic       Tb;       // road B vehicle present
    logic       ped_req;  // walk button, a single-cycle pulse is enough
    logic       emerg;    // emergency preempt, only honoured with TL_SCHED_EMERG_EN
    logic [1:0] La;       // road A light: 00 green, 01 yellow, 10 red
    logic [1:0] Lb;       // road B light, same encoding
    logic       walk;     // pedestrian walk lamp
    logic [2:0] phase;    // current scheduler state, for debug

    modport master (
        output Ta, Tb, ped_req, emerg,
        input  La, Lb, walk, phase
    );

    modport slave (
        input  Ta, Tb, ped_req, emerg,
        output La, Lb, walk, phase
    );
endinterface

// File: rtl/tl_sched.sv
// tl_sched: phase scheduler for a two-road intersection that shares one pedestrian crossing.
// Each road runs the sequence green -> yellow -> all-red. A latched walk request inserts a PED phase.
// Optional feature macro TL_SCHED_EMERG_EN adds emergency preemption into an all-red HOLD state.
// Without the macro, the emerg input is ignored and HOLD cannot be reached.
//
// state | meaning
// AG    | road A green, road B red
// AY    | road A yellow, road B red
// AR    | all-red clearance after road A
// BG    | road B green, road A red
// BY    | road B yellow, road A red
// BR    | all-red clearance after road B
// PED   | all red, walk lamp lit
// HOLD  | emergency all-red hold (TL_SCHED_EMERG_EN only)
module tl_sched #(
    parameter int TW        = 6,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic     clk,
    input  logic     reset,
    tl_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_AG   = 3'd0,
        S_AY   = 3'd1,
        S_AR   = 3'd2,
        S_BG   = 3'd3,
        S_BY   = 3'd4,
        S_BR   = 3'd5,
        S_PED  = 3'd6,
        S_HOLD = 3'd7
    } state_t;

    localparam logic [1:0] L_GRN = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_RED = 2'b10;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    localparam logic [TW-1:0] C_MIN    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] C_MAX    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] C_YELLOW = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] C_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] C_WALK   = TW'(WALK_T - 1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_cnt;
    logic            r_ped_pend;
    logic            r_last;
    logic [1:0]      r_la;
    logic [1:0]      r_lb;
    logic            r_walk;

    logic [1:0]      w_la;
    logic [1:0]      w_lb;
    logic            w_walk;
    logic            w_state_chg;
    logic            w_min_ok;
    logic            w_max_hit;
    logic            w_comp_a;
    logic            w_comp_b;
    logic            w_emerg;
    logic            w_emerg_pend;

    assign w_state_chg = (w_next != r_state);
    assign w_min_ok    = (r_cnt >= C_MIN);
    assign w_max_hit   = (r_cnt == C_MAX);
    // Competing demand against the road that currently has green.
    assign w_comp_a    = bus.Tb | r_ped_pend;
    assign w_comp_b    = bus.Ta | r_ped_pend;

`ifdef TL_SCHED_EMERG_EN
    logic r_emerg_pend;

    assign w_emerg      = bus.emerg;
    assign w_emerg_pend = r_emerg_pend;

    // Remember a preempt seen during a phase so the phase can finish before HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_emerg_pend <= 1'b0;
        end else if (w_next == S_HOLD) begin
            r_emerg_pend <= 1'b0;
        end else if (bus.emerg) begin
            r_emerg_pend <= 1'b1;
        end
    end
`else
    assign w_emerg      = 1'b0;
    assign w_emerg_pend = 1'b0;
`endif

    // Next-state selection from dwell counter, sensor demand and pending walk request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_AG: begin
                if (w_emerg) begin
                    w_next = S_AY;
                end else if (w_min_ok && w_comp_a && (!bus.Ta || w_max_hit)) begin
                    w_next = S_AY;
                end
            end
            S_AY: begin
                if (r_cnt == C_YELLOW) begin
                    w_next = S_AR;
                end
            end
            S_AR: begin
                if (r_cnt == C_ALLRED) begin
                    if (w_emerg || w_emerg_pend) begin
                        w_next = S_HOLD;
                    end else if (r_ped_pend) begin
                        w_next = S_PED;
                    end else begin
                        w_next = S_BG;
                    end
                end
            end
            S_BG: begin
                if (w_emerg) begin
                    w_next = S_BY;
                end else if (w_min_ok && w_comp_b && (!bus.Tb || w_max_hit)) begin
                    w_next = S_BY;
                end
            end
            S_BY: begin
                if (r_cnt == C_YELLOW) begin
                    w_next = S_BR;
                end
            end
            S_BR: begin
                if (r_cnt == C_ALLRED) begin
                    if (w_emerg || w_emerg_pend) begin
                        w_next = S_HOLD;
                    end else if (r_ped_pend) begin
                        w_next = S_PED;
                    end else begin
                        w_next = S_AG;
                    end
                end
            end
            S_PED: begin
                if (w_emerg) begin
                    w_next = S_HOLD;
                end else if (r_cnt == C_WALK) begin
                    w_next = (r_last == LAST_A) ? S_BG : S_AG;
                end
            end
            S_HOLD: begin
                if (!w_emerg) begin
                    w_next = (r_last == LAST_A) ? S_BG : S_AG;
                end
            end
            default: w_next = S_AG;
        endcase
    end

    // Lamp decode of the next state so the lamps change on the same edge as phase.
    always_comb begin
        w_la   = L_RED;
        w_lb   = L_RED;
        w_walk = 1'b0;
        case (w_next)
            S_AG:    w_la   = L_GRN;
            S_AY:    w_la   = L_YEL;
            S_BG:    w_lb   = L_GRN;
            S_BY:    w_lb   = L_YEL;
            S_PED:   w_walk = 1'b1;
            default: w_walk = 1'b0;
        endcase
    end

    // State register and registered lamp outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_AG;
            r_la    <= L_GRN;
            r_lb    <= L_RED;
            r_walk  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_la    <= w_la;
            r_lb    <= w_lb;
            r_walk  <= w_walk;
        end
    end

    // Dwell counter: clears on any state change and saturates on green so long greens keep their timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_chg) begin
            r_cnt <= '0;
        end else if (((r_state == S_AG) || (r_state == S_BG)) && w_max_hit) begin
            r_cnt <= r_cnt;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Walk request latch. A press during the walk, or on the edge that starts it, is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ped_pend <= 1'b0;
        end else if ((w_next == S_PED) && (r_state != S_PED)) begin
            r_ped_pend <= 1'b0;
        end else if (bus.ped_req && (r_state != S_PED)) begin
            r_ped_pend <= 1'b1;
        end
    end

    // Record which road cleared last so PED and HOLD can hand green to the other road.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= LAST_A;
        end else if ((r_state == S_AR) && w_state_chg) begin
            r_last <= LAST_A;
        end else if ((r_state == S_BR) && w_state_chg) begin
            r_last <= LAST_B;
        end
    end

    assign bus.La    = r_la;
    assign bus.Lb    = r_lb;
    assign bus.walk  = r_walk;
    assign bus.phase = r_state;

endmodule

// File: tb/tb_tl_sched.sv
// tb_tl_sched: directed scoreboard bench for tl_sched.
// Each step queues the expected lamps and phase, then advances one clock and compares the DUT against the queue.
// Compile with TL_SCHED_EMERG_EN to exercise emergency hold.
module tb_tl_sched;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] RED = 2'b10;

    localparam logic [2:0] P_AG   = 3'd0;
    localparam logic [2:0] P_AY   = 3'd1;
    localparam logic [2:0] P_AR   = 3'd2;
    localparam logic [2:0] P_BG   = 3'd3;
    localparam logic [2:0] P_BY   = 3'd4;
    localparam logic [2:0] P_BR   = 3'd5;
    localparam logic [2:0] P_PED  = 3'd6;
    localparam logic [2:0] P_HOLD = 3'd7;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    tl_sched_if bus_if();

    tl_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [1:0] la, input logic [1:0] lb,
                            input logic w, input logic [2:0] ph);
        exp_t e;
        e.tag = tag;
        e.v   = {la, lb, w, ph};
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t       e;
        logic [7:0] obs;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {bus_if.La, bus_if.Lb, bus_if.walk, bus_if.phase};
            n_assert++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: got La=%b Lb=%b walk=%b phase=%0d, expected La=%b Lb=%b walk=%b phase=%0d",
                       e.tag, obs[7:6], obs[5:4], obs[3], obs[2:0], e.v[7:6], e.v[5:4], e.v[3], e.v[2:0]);
            end
        end
    endtask

    // Checks the outputs without a clock edge, for asynchronous reset.
    task automatic check_now(input string tag, input logic [1:0] la, input logic [1:0] lb,
                             input logic w, input logic [2:0] ph);
        push_exp(tag, la, lb, w, ph);
        pop_chk();
    endtask

    // Advances n edges and checks every edge against the same expected lamps and phase.
    task automatic run_exp(input int n, input string tag, input logic [1:0] la, input logic [1:0] lb,
                           input logic w, input logic [2:0] ph);
        for (int i = 0; i < n; i++) begin
            push_exp(tag, la, lb, w, ph);
            @(posedge clk);
            #1;
            pop_chk();
        end
    endtask

    // Pulses reset between edges and checks the reset state while reset is held.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check_now(tag, GRN, RED, 1'b0, P_AG);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus_if.Ta      = 1'b0;
        bus_if.Tb      = 1'b0;
        bus_if.ped_req = 1'b0;
        bus_if.emerg   = 1'b0;
        #1;

        // Test 1: only road A demand, so AG holds for 100 cycles.
        do_reset("reset_state");
        bus_if.Ta = 1'b1;
        run_exp(100, "t1_a_only_hold", GRN, RED, 1'b0, P_AG);

        // Test 2: only road B demand, so AG hands over after MIN_GREEN.
        bus_if.Ta = 1'b0;
        bus_if.Tb = 1'b1;
        do_reset("t2_reset");
        run_exp(7, "t2_ag_min", GRN, RED, 1'b0, P_AG);
        run_exp(3, "t2_ay", YEL, RED, 1'b0, P_AY);
        run_exp(1, "t2_ar", RED, RED, 1'b0, P_AR);
        run_exp(1, "t2_bg_entry", RED, GRN, 1'b0, P_BG);

        // Test 3: both roads busy, so each green runs to MAX_GREEN.
        bus_if.Ta = 1'b1;
        bus_if.Tb = 1'b1;
        run_exp(31, "t3_bg_max", RED, GRN, 1'b0, P_BG);
        run_exp(3, "t3_by", RED, YEL, 1'b0, P_BY);
        run_exp(1, "t3_br", RED, RED, 1'b0, P_BR);
        run_exp(32, "t3_ag_max", GRN, RED, 1'b0, P_AG);
        run_exp(3, "t3_ay", YEL, RED, 1'b0, P_AY);
        run_exp(1, "t3_ar", RED, RED, 1'b0, P_AR);
        run_exp(1, "t3_bg_entry", RED, GRN, 1'b0, P_BG);

        // Test 4: a single walk press with no vehicles produces a PED phase, and then BG.
        bus_if.Ta = 1'b0;
        bus_if.Tb = 1'b0;
        do_reset("t4_reset");
        run_exp(2, "t4_ag_pre", GRN, RED, 1'b0, P_AG);
        bus_if.ped_req = 1'b1;
        run_exp(1, "t4_ag_press", GRN, RED, 1'b0, P_AG);
        bus_if.ped_req = 1'b0;
        run_exp(4, "t4_ag_min", GRN, RED, 1'b0, P_AG);
        run_exp(3, "t4_ay", YEL, RED, 1'b0, P_AY);
        run_exp(1, "t4_ar", RED, RED, 1'b0, P_AR);
        run_exp(6, "t4_ped_walk", RED, RED, 1'b1, P_PED);
        // BG with no demand holds only if the walk request was cleared on PED entry.
        run_exp(40, "t4_bg_idle", RED, GRN, 1'b0, P_BG);

        // Test 5: reset in BY returns to AG immediately and clears a pending walk.
        bus_if.Ta = 1'b1;
        run_exp(1, "t5_by_entry", RED, YEL, 1'b0, P_BY);
        bus_if.Ta      = 1'b0;
        bus_if.ped_req = 1'b1;
        run_exp(1, "t5_by_press", RED, YEL, 1'b0, P_BY);
        bus_if.ped_req = 1'b0;
        do_reset("t5_async_reset");
        run_exp(20, "t5_ag_after_reset", GRN, RED, 1'b0, P_AG);

        // Test 6: emergency preempt.
        do_reset("t6_reset");
        run_exp(2, "t6_ag_pre", GRN, RED, 1'b0, P_AG);
        bus_if.emerg = 1'b1;
`ifdef TL_SCHED_EMERG_EN
        run_exp(3, "t6_ay_forced", YEL, RED, 1'b0, P_AY);
        run_exp(1, "t6_ar", RED, RED, 1'b0, P_AR);
        run_exp(6, "t6_hold", RED, RED, 1'b0, P_HOLD);
        bus_if.emerg = 1'b0;
        run_exp(1, "t6_bg_after_hold", RED, GRN, 1'b0, P_BG);
`else
        run_exp(20, "t6_emerg_ignored", GRN, RED, 1'b0, P_AG);
        bus_if.emerg = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
